pattern_detector: RTL and testbench

//   Receive-side counterpart of the ring-counter/ASCII-coder pattern generator.

---
 rtl/pattern_detector_pkg.sv | 27 ++
 rtl/pattern_detector_if.sv | 13 +
 rtl/pattern_detector_char_rom.sv | 9 +
 rtl/pattern_detector.sv | 73 +++++++
 tb/tb_pattern_detector.sv | 130 +++++++++++++
 5 files changed

// File: rtl/pattern_detector_pkg.sv
// pattern_detector_pkg: pattern table, ASCII constants, state enum and compare helpers (CASE_FOLD_EN selects case-insensitive letters)
package pattern_detector_pkg;
   localparam int PAT_LEN = 13;
   localparam logic [6:0] CH_T     = 7'h54;
   localparam logic [6:0] CH_SPACE = 7'h20;
   localparam logic [6:0] PATTERN [PAT_LEN] = '{
      CH_T, 7'h61, 7'h6C, 7'h61, 7'h6C, CH_SPACE,
      7'h4A, 7'h61, 7'h77, 7'h61, 7'h69, 7'h64, CH_SPACE
   };
   typedef enum logic {HUNT, TRACK} state_t;
   // Letters collapse to upper case when folding is built in; everything else is compared exactly.
   function automatic logic [6:0] fold(input logic [6:0] c);
`ifdef CASE_FOLD_EN
      logic [6:0] u;
      u = c & 7'h5F;
      return (u >= 7'h41 && u <= 7'h5A) ? u : c;
`else
      return c;
`endif
   endfunction
   function automatic logic [0:PAT_LEN-1] onehot(input logic [3:0] i);
      logic [0:PAT_LEN-1] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction
endpackage

// File: rtl/pattern_detector_if.sv
// pattern_detector_if: character stream in, tracking status out
interface pattern_detector_if
   import pattern_detector_pkg::*;
#(parameter int ERR_W = 8);
   logic [6:0]         c_in;
   logic               c_valid;
   logic [0:PAT_LEN-1] q;
   logic               match;
   logic               locked;
   logic [ERR_W-1:0]   err_cnt;
   modport master (output c_in, c_valid, input q, match, locked, err_cnt);
   modport slave  (input c_in, c_valid, output q, match, locked, err_cnt);
endinterface

// File: rtl/pattern_detector_char_rom.sv
// pattern_char_rom: pattern index to expected character, zero beyond the table
module pattern_char_rom
   import pattern_detector_pkg::*;
(
   input  logic [3:0] idx_i,
   output logic [6:0] ch_o
);
   assign ch_o = (idx_i < 4'(PAT_LEN)) ? PATTERN[idx_i] : 7'h00;
endmodule

// File: rtl/pattern_detector.sv
// pattern_detector: tracks an ASCII stream against the fixed pattern, pulses on each full match, locks after repeats (CASE_FOLD_EN enables case-insensitive letters)
module pattern_detector
   import pattern_detector_pkg::*;
#(
   parameter int LOCK_COUNT = 2,
   parameter int ERR_W      = 8
)
(
   input logic clk_i,
   input logic rst_ni,
   pattern_detector_if.slave bus
);
   localparam int LW = $clog2(LOCK_COUNT + 1);
   state_t             state_q;
   logic [3:0]         idx_q;
   logic [0:PAT_LEN-1] q_q;
   logic               match_q;
   logic               locked_q;
   logic [LW-1:0]      lock_cnt_q;
   logic [LW-1:0]      lock_cnt_d;
   logic [ERR_W-1:0]   err_q;
   logic [6:0]         exp_ch;
   logic               hit;
   logic               is_sync;
   logic               last;
   pattern_char_rom u_rom (.idx_i(idx_q), .ch_o(exp_ch));
   // In HUNT idx is 0, so the expected char is the sync char and one compare serves both states.
   assign hit        = fold(bus.c_in) == fold(exp_ch);
   assign is_sync    = fold(bus.c_in) == fold(CH_T);
   assign last       = idx_q == 4'(PAT_LEN - 1);
   assign lock_cnt_d = (lock_cnt_q == LW'(LOCK_COUNT)) ? lock_cnt_q : lock_cnt_q + LW'(1);
   // FSM with registered position, match pulse, lock and error status
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= HUNT;
         idx_q      <= 4'd0;
         q_q        <= '0;
         match_q    <= 1'b0;
         locked_q   <= 1'b0;
         lock_cnt_q <= '0;
         err_q      <= '0;
      end else begin
         match_q <= 1'b0;
         if (bus.c_valid) begin
            if (hit) begin
               state_q <= TRACK;
               q_q     <= onehot(idx_q);
               if (last) begin
                  idx_q      <= 4'd0;
                  match_q    <= 1'b1;
                  lock_cnt_q <= lock_cnt_d;
                  locked_q   <= locked_q | (lock_cnt_d == LW'(LOCK_COUNT));
               end else begin
                  idx_q <= idx_q + 4'd1;
               end
            end else begin
               if (state_q == TRACK) begin
                  err_q      <= (&err_q) ? err_q : err_q + ERR_W'(1);
                  locked_q   <= 1'b0;
                  lock_cnt_q <= '0;
               end
               state_q <= is_sync ? TRACK : HUNT;
               idx_q   <= is_sync ? 4'd1 : 4'd0;
               q_q     <= is_sync ? onehot(4'd0) : '0;
            end
         end
      end
   end
   assign bus.q       = q_q;
   assign bus.match   = match_q;
   assign bus.locked  = locked_q;
   assign bus.err_cnt = err_q;
endmodule

// File: tb/tb_pattern_detector.sv
// tb_pattern_detector: directed checks of pattern tracking, lock, error saturation and reset
module tb_pattern_detector;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   passed = 0;
   int   total = 0;
   int   fails = 0;
   string pat = "Talal Jawaid ";
   always #5 clk = ~clk;
   pattern_detector_if #(.ERR_W(8)) bus ();
   pattern_detector #(.LOCK_COUNT(2), .ERR_W(8)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
   function automatic logic [31:0] oh(input int i);
      return 32'd1 << (12 - i);
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic send(input byte ch);
      bus.c_in = ch[6:0];
      bus.c_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.c_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      bus.c_valid = 1'b1;
      bus.c_in = 7'h54;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_q"}, 32'(bus.q), 32'd0);
      chk({tag, "_match"}, 32'(bus.match), 32'd0);
      chk({tag, "_locked"}, 32'(bus.locked), 32'd0);
      chk({tag, "_err"}, 32'(bus.err_cnt), 32'd0);
   endtask
   initial begin
      bus.c_in = 7'h00;
      bus.c_valid = 1'b0;
      #1;
      do_reset();
      chk_reset("reset");
      for (int i = 0; i < 13; i++) begin
         send(pat[i]);
         chk("walk_q", 32'(bus.q), oh(i));
         chk("walk_match", 32'(bus.match), 32'(i == 12));
         chk("walk_locked", 32'(bus.locked), 32'd0);
      end
      chk("walk_err", 32'(bus.err_cnt), 32'd0);
      idle();
      chk("gap_q_hold", 32'(bus.q), oh(12));
      chk("gap_match_low", 32'(bus.match), 32'd0);
      do_reset();
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 13; i++) begin
            send(pat[i]);
            chk("b2b_q", 32'(bus.q), oh(i));
            chk("b2b_match", 32'(bus.match), 32'(i == 12));
            chk("b2b_locked", 32'(bus.locked), 32'(p == 1 && i == 12));
         end
      for (int i = 0; i < 13; i++) begin
         repeat ($urandom_range(0, 2)) begin
            idle();
            chk("rgap_q_hold", 32'(bus.q), (i == 0) ? oh(12) : oh(i - 1));
            chk("rgap_match", 32'(bus.match), 32'd0);
         end
         send(pat[i]);
         chk("rgap_q", 32'(bus.q), oh(i));
         chk("rgap_match", 32'(bus.match), 32'(i == 12));
         chk("rgap_locked", 32'(bus.locked), 32'd1);
      end
      send("T"); send("a"); send("l"); send("a"); send("x");
      chk("talax_err", 32'(bus.err_cnt), 32'd1);
      chk("talax_locked", 32'(bus.locked), 32'd0);
      chk("talax_q", 32'(bus.q), 32'd0);
      send("T"); send("a"); send("l"); send("T");
      chk("resync_err", 32'(bus.err_cnt), 32'd2);
      chk("resync_q", 32'(bus.q), oh(0));
      for (int i = 1; i < 13; i++) begin
         send(pat[i]);
         chk("resync_walk_q", 32'(bus.q), oh(i));
      end
      chk("resync_match", 32'(bus.match), 32'd1);
      chk("resync_locked", 32'(bus.locked), 32'd0);
      for (int k = 1; k <= 300; k++) begin
         send("T");
         send("x");
         chk("err_sat", 32'(bus.err_cnt), (k + 2 > 255) ? 32'd255 : 32'(k + 2));
      end
      do_reset();
      send("T"); send("a"); send("l"); send("a");
      chk("mid_q", 32'(bus.q), oh(3));
      rst_n = 1'b0;
      send("l");
      rst_n = 1'b1;
      chk_reset("mid_reset");
      send("T");
      chk("mid_resync_q", 32'(bus.q), oh(0));
      do_reset();
      begin
         string mixed;
         mixed = "tALAL jAWAID ";
         for (int i = 0; i < 13; i++) begin
            send(mixed[i]);
`ifdef CASE_FOLD_EN
            chk("fold_q", 32'(bus.q), oh(i));
            chk("fold_match", 32'(bus.match), 32'(i == 12));
`else
            chk("exact_q", 32'(bus.q), 32'd0);
            chk("exact_match", 32'(bus.match), 32'd0);
`endif
         end
      end
      chk("mixed_err", 32'(bus.err_cnt), 32'd0);
      idle();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
